vip_edge_stats: RTL and testbench

//  Sits directly downstream of the Sobel stage and consumes its gradient-magnitude stream.

---
 rtl/vip_edge_stats.sv | 169 ++++++++++++++++
 tb/tb_vip_edge_stats.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_edge_stats.sv
// -----------------------------------------------------------------------------
// vip_edge_stats
//   Binarizes a gradient-magnitude stream (from a Sobel stage) against a
//   per-frame threshold, re-emits it as an edge map with 1-clk delayed framing,
//   and publishes per-frame edge statistics (pixel count + bounding box) at
//   every frame boundary (rising edge of in_vsync).
//
// Ports
//   pclk, rst_n        pixel clock, asynchronous active-low reset
//   in_href/in_vsync   line valid / frame sync from upstream
//   in_data            gradient magnitude
//   threshold          edge threshold, sampled only at a frame boundary
//   out_href/out_vsync framing delayed 1 clk
//   out_data           all-ones on an edge pixel, else 0
//   edge_count         edge pixels in the last completed frame
//   x_min/x_max        bounding-box columns of the last completed frame
//   y_min/y_max        bounding-box rows of the last completed frame
//   bbox_valid         last completed frame contained at least one edge
//   stats_valid        1-clk pulse when the statistics outputs update
// -----------------------------------------------------------------------------
module vip_edge_stats #(
  parameter  int BITS   = 8,
  parameter  int WIDTH  = 640,
  parameter  int HEIGHT = 480,
  localparam int CW     = $clog2(WIDTH * HEIGHT + 1),
  localparam int XW     = $clog2(WIDTH),
  localparam int YW     = $clog2(HEIGHT)
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_data,
  input  logic [BITS-1:0] threshold,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_data,
  output logic [CW-1:0]   edge_count,
  output logic [XW-1:0]   x_min,
  output logic [XW-1:0]   x_max,
  output logic [YW-1:0]   y_min,
  output logic [YW-1:0]   y_max,
  output logic            bbox_valid,
  output logic            stats_valid
);

  localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH * HEIGHT);

  logic            r_vsync_d;
  logic            r_href_d;
  logic            r_frame_seen;
  logic [BITS-1:0] r_thr_shadow;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [CW-1:0]   r_cnt;
  logic [XW-1:0]   r_xmin, r_xmax;
  logic [YW-1:0]   r_ymin, r_ymax;

  logic            w_boundary;
  logic            w_href_fall;
  logic            w_edge;
  logic [BITS-1:0] w_thr;
  logic [XW-1:0]   w_x, w_x_nxt;
  logic [YW-1:0]   w_y, w_y_nxt;
  logic [CW-1:0]   w_cnt_base, w_cnt_nxt;
  logic [XW-1:0]   w_xmin_base, w_xmax_base, w_xmin_nxt, w_xmax_nxt;
  logic [YW-1:0]   w_ymin_base, w_ymax_base, w_ymin_nxt, w_ymax_nxt;

  // A pixel arriving in the boundary cycle already belongs to the new frame:
  // it sees the new threshold, position (0,0) and freshly cleared accumulators.
  // The published stats come from the registered accumulators, so they never
  // include it.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_boundary  = in_vsync & ~r_vsync_d;
    w_href_fall = r_href_d & ~in_href;
    w_thr       = w_boundary ? threshold : r_thr_shadow;
    w_x         = w_boundary ? '0 : r_x;
    w_y         = w_boundary ? '0 : r_y;
    w_edge      = in_href && (in_data >= w_thr);

    w_cnt_base  = w_boundary ? '0     : r_cnt;
    w_xmin_base = w_boundary ? X_LAST : r_xmin;
    w_xmax_base = w_boundary ? '0     : r_xmax;
    w_ymin_base = w_boundary ? Y_LAST : r_ymin;
    w_ymax_base = w_boundary ? '0     : r_ymax;

    w_cnt_nxt  = w_cnt_base;
    w_xmin_nxt = w_xmin_base;
    w_xmax_nxt = w_xmax_base;
    w_ymin_nxt = w_ymin_base;
    w_ymax_nxt = w_ymax_base;
    if (w_edge) begin
      if (w_cnt_base != CNT_MAX) w_cnt_nxt  = w_cnt_base + 1'b1;
      if (w_x < w_xmin_base)     w_xmin_nxt = w_x;
      if (w_x > w_xmax_base)     w_xmax_nxt = w_x;
      if (w_y < w_ymin_base)     w_ymin_nxt = w_y;
      if (w_y > w_ymax_base)     w_ymax_nxt = w_y;
    end

    // Counters saturate so overlong lines/frames fold into the last column/row.
    w_x_nxt = '0;
    if (in_href) w_x_nxt = (w_x != X_LAST) ? w_x + 1'b1 : w_x;

    w_y_nxt = r_y;
    if (w_boundary)                       w_y_nxt = '0;
    else if (w_href_fall && r_y != Y_LAST) w_y_nxt = r_y + 1'b1;
  end

  assign out_href  = r_href_d;
  assign out_vsync = r_vsync_d;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d    <= 1'b0;
      r_href_d     <= 1'b0;
      r_frame_seen <= 1'b0;
      r_thr_shadow <= '1;
      r_x          <= '0;
      r_y          <= '0;
      r_cnt        <= '0;
      r_xmin       <= X_LAST;
      r_xmax       <= '0;
      r_ymin       <= Y_LAST;
      r_ymax       <= '0;
      out_data     <= '0;
      edge_count   <= '0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      bbox_valid   <= 1'b0;
      stats_valid  <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the values from before this edge.
      r_vsync_d <= in_vsync;
      r_href_d  <= in_href;
      out_data  <= w_edge ? '1 : '0;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_cnt     <= w_cnt_nxt;
      r_xmin    <= w_xmin_nxt;
      r_xmax    <= w_xmax_nxt;
      r_ymin    <= w_ymin_nxt;
      r_ymax    <= w_ymax_nxt;

      stats_valid <= 1'b0;
      if (w_boundary) begin
        r_frame_seen <= 1'b1;
        r_thr_shadow <= threshold;
        // The first boundary after reset closes a partial frame: not reported.
        if (r_frame_seen) begin
          stats_valid <= 1'b1;
          edge_count  <= r_cnt;
          bbox_valid  <= (r_cnt != '0);
          // An empty frame reports a zero box rather than the init extremes.
          x_min       <= (r_cnt != '0) ? r_xmin : '0;
          x_max       <= (r_cnt != '0) ? r_xmax : '0;
          y_min       <= (r_cnt != '0) ? r_ymin : '0;
          y_max       <= (r_cnt != '0) ? r_ymax : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vip_edge_stats.sv
// -----------------------------------------------------------------------------
// tb_vip_edge_stats
//   Directed bench for vip_edge_stats on a tiny 8x4 frame. Each scenario task
//   drives framing/pixels and compares observed outputs against hand-computed
//   values; a summary line closes the run.
// -----------------------------------------------------------------------------
module tb_vip_edge_stats;

  localparam int BITS   = 8;
  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;
  localparam int CW     = $clog2(WIDTH * HEIGHT + 1);
  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);

  // {stats_valid, edge_count, x_min, x_max, y_min, y_max, bbox_valid}
  typedef logic [1+CW+2*XW+2*YW+1-1:0] snap_t;

  logic            pclk = 1'b0;
  logic            rst_n;
  logic            in_href;
  logic            in_vsync;
  logic [BITS-1:0] in_data;
  logic [BITS-1:0] threshold;
  logic            out_href;
  logic            out_vsync;
  logic [BITS-1:0] out_data;
  logic [CW-1:0]   edge_count;
  logic [XW-1:0]   x_min, x_max;
  logic [YW-1:0]   y_min, y_max;
  logic            bbox_valid;
  logic            stats_valid;

  int vectors = 0;
  int errors  = 0;

  always #5 pclk = ~pclk;

  vip_edge_stats #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .in_href    (in_href),
    .in_vsync   (in_vsync),
    .in_data    (in_data),
    .threshold  (threshold),
    .out_href   (out_href),
    .out_vsync  (out_vsync),
    .out_data   (out_data),
    .edge_count (edge_count),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max),
    .bbox_valid (bbox_valid),
    .stats_valid(stats_valid)
  );

  function automatic snap_t stats_snap();
    return {stats_valid, edge_count, x_min, x_max, y_min, y_max, bbox_valid};
  endfunction

  function automatic snap_t exp_snap(input logic sv, input int cnt, input int x0,
                                     input int x1, input int y0, input int y1,
                                     input logic bv);
    return {sv, CW'(cnt), XW'(x0), XW'(x1), YW'(y0), YW'(y1), bv};
  endfunction

  // Inputs change on the falling edge; the DUT samples on the rising edge.
  task automatic drive(input logic h, input logic v, input logic [BITS-1:0] d);
    @(negedge pclk);
    in_href  = h;
    in_vsync = v;
    in_data  = d;
  endtask

  task automatic settle();
    @(posedge pclk);
    #1;
  endtask

  // Raises vsync (no pixel), samples the stats right after the boundary edge
  // and stats_valid one clock later, then drops vsync.
  task automatic vsync_rise(output snap_t s1, output logic sv2);
    drive(1'b0, 1'b1, '0);
    settle();
    s1 = stats_snap();
    drive(1'b0, 1'b1, '0);
    settle();
    sv2 = stats_valid;
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
  endtask

  function automatic logic [BITS-1:0] pix_val(input int mode, input int x, input int y);
    case (mode)
      2:       return (x == 3 && y == 2) ? 8'd200 : 8'd0;
      4:       return 8'd254;
      5:       return 8'd50;
      6:       return ((x == 0 && y == 1) || (y == 3 && x >= 8)) ? 8'd50 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  // Sends HEIGHT lines of len pixels; counts non-zero out_data cycles and the
  // (x,y) of the last one, observed 1 clk after each pixel.
  task automatic send_frame(input int mode, input int len, output int nz,
                            output int hx, output int hy);
    nz = 0; hx = -1; hy = -1;
    for (int y = 0; y < HEIGHT; y++) begin
      for (int x = 0; x < len; x++) begin
        drive(1'b1, 1'b0, pix_val(mode, x, y));
        if (mode == 5 && y == 2 && x == 0) threshold = 8'd10;
        settle();
        if (out_data != '0) begin
          nz++; hx = x; hy = y;
        end
      end
      drive(1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, '0);
    end
  endtask

  task automatic cmp_snap(input string name, input snap_t act, input snap_t exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    snap_t s1;
    logic  sv2;
    rst_n = 1'b0; in_href = 1'b0; in_vsync = 1'b0; in_data = '0;
    threshold = 8'd100;
    repeat (3) @(posedge pclk);
    #1;
    vectors++;
    if ({out_href, out_vsync, out_data, stats_snap()} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {out_href, out_vsync, out_data, stats_snap()});
    end
    @(negedge pclk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0);
    vsync_rise(s1, sv2);
    cmp_snap("first_boundary_no_stats", s1, '0);
  endtask

  task automatic test_single_edge();
    int    nz, hx, hy;
    snap_t s1;
    logic  sv2;
    send_frame(2, WIDTH, nz, hx, hy);
    vectors++;
    if (nz !== 1 || hx !== 3 || hy !== 2) begin
      errors++;
      $display("FAIL single_edge_map: got n=%0d at (%0d,%0d) expected n=1 at (3,2)", nz, hx, hy);
    end
    threshold = 8'd0;
    vsync_rise(s1, sv2);
    cmp_snap("single_edge_stats", s1, exp_snap(1'b1, 1, 3, 3, 2, 2, 1'b1));
    vectors++;
    if (sv2 !== 1'b0) begin
      errors++;
      $display("FAIL stats_valid_width: got %b expected 0", sv2);
    end
  endtask

  task automatic test_all_edges();
    int    nz, hx, hy;
    snap_t s1;
    logic  sv2;
    send_frame(3, WIDTH, nz, hx, hy);
    vectors++;
    if (nz !== 32) begin
      errors++;
      $display("FAIL all_edges_map: got %0d expected 32", nz);
    end
    threshold = 8'd255;
    vsync_rise(s1, sv2);
    cmp_snap("all_edges_stats", s1, exp_snap(1'b1, 32, 0, 7, 0, 3, 1'b1));
  endtask

  task automatic test_no_edges();
    int    nz, hx, hy;
    snap_t s1;
    logic  sv2;
    send_frame(4, WIDTH, nz, hx, hy);
    vectors++;
    if (nz !== 0) begin
      errors++;
      $display("FAIL no_edges_map: got %0d expected 0", nz);
    end
    threshold = 8'd100;
    vsync_rise(s1, sv2);
    cmp_snap("no_edges_stats", s1, exp_snap(1'b1, 0, 0, 0, 0, 0, 1'b0));
  endtask

  task automatic test_threshold_shadow();
    int    nz, hx, hy;
    snap_t s1;
    logic  sv2;
    send_frame(5, WIDTH, nz, hx, hy);  // threshold drops to 10 mid-frame
    vectors++;
    if (nz !== 0) begin
      errors++;
      $display("FAIL thr_midframe_map: got %0d expected 0", nz);
    end
    vsync_rise(s1, sv2);
    cmp_snap("thr_midframe_stats", s1, exp_snap(1'b1, 0, 0, 0, 0, 0, 1'b0));
    send_frame(5, WIDTH, nz, hx, hy);
    vectors++;
    if (nz !== 32) begin
      errors++;
      $display("FAIL thr_nextframe_map: got %0d expected 32", nz);
    end
    vsync_rise(s1, sv2);
    cmp_snap("thr_nextframe_stats", s1, exp_snap(1'b1, 32, 0, 7, 0, 3, 1'b1));
  endtask

  // Overlong lines plus a pixel in the boundary cycle itself.
  task automatic test_back_to_back();
    int    nz, hx, hy;
    snap_t s1;
    logic  sv2;
    send_frame(6, 10, nz, hx, hy);     // threshold 10; edges (0,1),(8,3),(9,3)
    vectors++;
    if (nz !== 3) begin
      errors++;
      $display("FAIL overlong_map: got %0d expected 3", nz);
    end
    threshold = 8'd5;                  // value 5: rejected by old 10, accepted by new 5
    drive(1'b1, 1'b1, 8'd5);
    settle();
    cmp_snap("boundary_prev_stats", stats_snap(), exp_snap(1'b1, 3, 0, 7, 1, 3, 1'b1));
    vectors++;
    if ({out_href, out_vsync, out_data} !== {1'b1, 1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL boundary_pixel_out: got %h expected 3ff", {out_href, out_vsync, out_data});
    end
    nz = 0;
    for (int x = 1; x < WIDTH; x++) begin
      drive(1'b1, 1'b0, 8'd0);
      settle();
      if (out_data != '0) nz++;
      if (x == 1) begin
        vectors++;
        if (stats_valid !== 1'b0) begin
          errors++;
          $display("FAIL boundary_pulse_width: got %b expected 0", stats_valid);
        end
      end
    end
    vectors++;
    if (nz !== 0) begin
      errors++;
      $display("FAIL boundary_line_map: got %0d expected 0", nz);
    end
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    vsync_rise(s1, sv2);
    cmp_snap("boundary_pixel_stats", s1, exp_snap(1'b1, 1, 0, 0, 0, 0, 1'b1));
  endtask

  task automatic test_midframe_reset();
    int    nz, hx, hy;
    snap_t s1;
    logic  sv2;
    drive(1'b1, 1'b0, 8'd255);         // threshold shadow is 5 -> edge
    settle();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_href, out_vsync, out_data, stats_snap()} !== '0) begin
      errors++;
      $display("FAIL midframe_reset_outputs: got %h expected 0", {out_href, out_vsync, out_data, stats_snap()});
    end
    drive(1'b0, 1'b0, '0);
    rst_n = 1'b1;
    threshold = 8'd0;
    drive(1'b1, 1'b0, 8'd9);
    drive(1'b0, 1'b0, '0);
    vsync_rise(s1, sv2);
    cmp_snap("post_reset_boundary", s1, '0);
    send_frame(3, WIDTH, nz, hx, hy);
    vsync_rise(s1, sv2);
    cmp_snap("post_reset_frame_stats", s1, exp_snap(1'b1, 32, 0, 7, 0, 3, 1'b1));
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_all_edges();
    test_no_edges();
    test_threshold_shadow();
    test_back_to_back();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
